nibble_serial_add_seq: RTL and testbench

Sequencer that streams wide operands through the 4-bit ripple adder one nibble per cycle, least significant nibble first. It chains the carry between nibbles and assembles the full-width sum and final carry. Sits directly around the 4-bit adder: drives its r1/r2/ci inputs and consumes its result/carry outputs. Valid/ready handshakes on both the operand side and the result side.

---
 rtl/nibble_serial_add_seq.sv | 188 ++++++++++++++++++
 tb/tb_nibble_serial_add_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq
//   Streams two WIDTH-bit operands through an external 4-bit ripple adder.
//   One nibble is processed per cycle, least significant nibble first. The
//   carry is chained between nibbles, and the full sum and carry-out are
//   assembled here.
//
//   Optional feature (macro ADD_SUB_SEQ_SUB_EN): adds a 'sub' input. When
//   sub=1 the block computes a - b as a + ~b + 1. In that case cout=1 means
//   no borrow occurred.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin [, sub])
//   add_r1/r2/ci        : drive the 4-bit adder (zero outside RUN)
//   add_result/carry    : combinational adder outputs, consumed same cycle
//   out_valid/out_ready : result handshake (sum, cout)
//
// Parameters
//   WIDTH   : operand width, a multiple of 4 and at least 4
//   NIBBLES : WIDTH/4, the number of adder passes per operation
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic [3:0]       add_r1,
  output logic [3:0]       add_r2,
  output logic             add_ci,
  input  logic [3:0]       add_result,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_chk
    $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operands and sum are held as nibble arrays so the running index selects
  // a nibble directly.
  logic [NIBBLES-1:0][3:0] a_q, a_d;
  logic [NIBBLES-1:0][3:0] b_q, b_d;
  logic [NIBBLES-1:0][3:0] sum_q, sum_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic                    ovld_q, ovld_d;

  logic accept;
  logic last;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    add_r1   = 4'd0;
    add_r2   = 4'd0;
    add_ci   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_r1 = a_q[idx_q];
        add_r2 = b_q[idx_q];
        add_ci = carry_q;
      end
      default: ;
    endcase
  end

  assign out_valid = ovld_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef ADD_SUB_SEQ_SUB_EN
          // Subtraction is a + ~b + 1, so cin is ignored.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_result;
        carry_d      = add_carry;
        if (last) begin
          // idx holds at the top nibble; it is reloaded on the next accept.
          cout_d = add_carry;
          ovld_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) ovld_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed bench for nibble_serial_add_seq (WIDTH=16). A behavioural 4-bit
// adder closes the loop around the DUT. Each expected value is hand-computed.
module tb_nibble_serial_add_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef ADD_SUB_SEQ_SUB_EN
  logic             sub;
`endif
  logic [3:0]       add_r1, add_r2;
  logic             add_ci;
  logic [3:0]       add_result;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic [4:0] adder5;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 4-bit ripple adder reference
  assign adder5     = {1'b0, add_r1} + {1'b0, add_r2} + {4'd0, add_ci};
  assign add_result = adder5[3:0];
  assign add_carry  = adder5[4];

  nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADD_SUB_SEQ_SUB_EN
    .sub(sub),
`endif
    .add_r1(add_r1), .add_r2(add_r2), .add_ci(add_ci),
    .add_result(add_result), .add_carry(add_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge from IDLE; returns with the DUT in RUN, idx=0.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic c);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Complete RUN; verify latency and the result; then release via out_ready.
  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec);
    tick(); tick(); tick();
    chk({tag, "_ovld_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_ovld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},  {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef ADD_SUB_SEQ_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_add_r1", {28'd0, add_r1}, 32'd0);
    chk("rst_add_ci", {31'd0, add_ci}, 32'd0);

    // 0x1234 + 0x0FFF: sum 0x2233, cout 0; nibble 0 drives 4 and F
    start_op(16'h1234, 16'h0FFF, 1'b0);
    chk("t1_r1_n0", {28'd0, add_r1}, 32'h4);
    chk("t1_r2_n0", {28'd0, add_r2}, 32'hF);
    chk("t1_in_ready_run", {31'd0, in_ready}, 32'd0);
    finish_op("t1", 16'h2233, 1'b0);

    // Same operands with cin=1
    start_op(16'h1234, 16'h0FFF, 1'b1);
    finish_op("t2", 16'h2234, 1'b0);

    // 0xFFFF + 0x0001: ci sequence 0,1,1,1; wraps to 0 with cout 1
    start_op(16'hFFFF, 16'h0001, 1'b0);
    chk("t3_ci_n0", {31'd0, add_ci}, 32'd0);
    tick(); chk("t3_ci_n1", {31'd0, add_ci}, 32'd1);
    tick(); chk("t3_ci_n2", {31'd0, add_ci}, 32'd1);
    tick(); chk("t3_ci_n3", {31'd0, add_ci}, 32'd1);
    tick();
    chk("t3_ovld", {31'd0, out_valid}, 32'd1);
    chk("t3_sum", {16'd0, sum}, 32'h0000);
    chk("t3_cout", {31'd0, cout}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: 0x1234 + 0x0FFF held for 5 cycles
    start_op(16'h1234, 16'h0FFF, 1'b0);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovld", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {16'd0, sum}, 32'h2233);
      chk("bp_cout", {31'd0, cout}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_ovld_clr", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready_idle", {31'd0, in_ready}, 32'd1);

    // in_valid during RUN and DONE is ignored; the 0xAAAA op is taken only from IDLE
    start_op(16'h0001, 16'h0001, 1'b0);
    a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("ign_ovld", {31'd0, out_valid}, 32'd1);
    chk("ign_sum", {16'd0, sum}, 32'h0002);
    a = 16'hAAAA; b = 16'h0000; cin = 1'b0; in_valid = 1'b1;
    tick();
    chk("ign_done_hold", {16'd0, sum}, 32'h0002);
    chk("ign_done_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("ign_idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick();  // accepts 0xAAAA + 0 here
    in_valid = 1'b0;
    finish_op("ign_next", 16'hAAAA, 1'b0);

    // Reset mid-RUN at idx=2 aborts the op
    start_op(16'h1234, 16'h0FFF, 1'b0);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_ovld", {31'd0, out_valid}, 32'd0);
    chk("mrst_sum", {16'd0, sum}, 32'd0);
    chk("mrst_add_r1", {28'd0, add_r1}, 32'd0);
    chk("mrst_add_r2", {28'd0, add_r2}, 32'd0);
    chk("mrst_add_ci", {31'd0, add_ci}, 32'd0);
    start_op(16'h00FF, 16'h0001, 1'b0);
    finish_op("mrst_next", 16'h0100, 1'b0);

`ifdef ADD_SUB_SEQ_SUB_EN
    sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b0);
    finish_op("sub_neg", 16'hFFFE, 1'b0);
    start_op(16'h0007, 16'h0005, 1'b0);
    finish_op("sub_pos", 16'h0002, 1'b1);
    sub = 1'b0;
    start_op(16'h0007, 16'h0005, 1'b1);
    finish_op("sub_off", 16'h000D, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
